hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
// - Pipeline hazard controller for the 5-stage MIPS core. Drives the EX-stage operand
//   forwarding selects (ForwardAE/ForwardBE), stage stalls and flushes.
// - Sequences load-use stalls, taken-branch squashes and multi-cycle MUL/DIV occupancy of EX.
// - Sits beside the stage registers; consumes decoded register addresses and control bits.
// PARAMETERS
// - MD_LAT  32  cycles EX is held by a MUL/DIV op (>=2); counter width $clog2(MD_LAT+1)
// - AW      5   register address width
// PORTS
// - clk            in   1   core clock; all state updates on rising edge
// - rst            in   1   synchronous reset, active-high
// - RsD,RtD        in   AW  source regs of instruction in ID
// - RsE,RtE        in   AW  source regs of instruction in EX
// - RegWriteAddrE/M/W  in AW  destination reg in EX/MEM/WB
// - RegWriteE/M/W  in   1   destination write enable per stage
// - MemtoRegE/M    in   1   instruction in EX/MEM is a load
// - BranchE        in   1   branch instruction in EX
// - ZeroE          in   1   ALU zero flag from EX (branch condition)
// - MulDivE        in   1   instruction in EX is MUL/DIV
// - ForwardAE,ForwardBE out 2  operand select: 00 regfile, 01 WB data, 10 ALUResM, 11 DataMemDM
// - StallF,StallD,StallE out 1  hold PC / IF-ID / ID-EX register
// - FlushD,FlushE,FlushM out 1  bubble IF-ID / ID-EX / EX-MEM register next edge
// - MulDivBusy     out  1   MUL/DIV sequence in progress
// BEHAVIOUR
// - Reset (rst=1 at edge): state<=IDLE, md_cnt<=0. While rst=1 every output is forced 0.
// - Forwarding (combinational, per operand, RsE for A / RtE for B):
//   M match (RegWriteM, addrM!=0, addrM==RsE): MemtoRegM ? 11 : 10;
//   else W match (RegWriteW, addrW!=0): 01; else 00. M beats W. Reg 0 never forwards.
// - Load-use (comb. detect): MemtoRegE & RegWriteE & addrE!=0 & (addrE==RsD | addrE==RtD)
//   -> StallF=StallD=1, FlushE=1 for exactly one cycle; next cycle load is in MEM, fwd code 11.
// - Branch: BranchE & ZeroE -> FlushD=FlushE=1 same cycle (2 squashed slots); no stall.
// - FSM states (enum): IDLE, MD_BUSY.
//   IDLE -> MD_BUSY when MulDivE & ~(BranchE&ZeroE); md_cnt<=MD_LAT-1.
//   MD_BUSY: StallF=StallD=StallE=1, FlushM=1, MulDivBusy=1; md_cnt decrements each cycle.
//   MD_BUSY -> IDLE when md_cnt==1 at edge; in the cycle md_cnt==0 would be reached the
//   op leaves EX: total EX occupancy = MD_LAT cycles, MulDivBusy high MD_LAT-1 cycles.
//   On entry cycle (IDLE, MulDivE) stalls/FlushM already asserted (combinational).
// - Priority (simultaneous events): rst > branch flush > MUL/DIV hold > load-use stall.
//   Branch taken cancels a same-cycle load-use stall (StallF/StallD=0, FlushD/FlushE=1).
//   Load-use detected during MD_BUSY: suppressed; re-evaluated when EX is released.
// - Forward selects remain valid during MD_BUSY (operands re-selected every cycle).
// - Reset mid-MD_BUSY: aborts to IDLE, counter 0, no residual stall.
// - No output is registered except via state/md_cnt; outputs settle within the cycle.
// STRUCTURE
// - mips_pkg: FWD_RF/FWD_WB/FWD_ALUM/FWD_MEMD 2-bit constants, hz_state_t enum, AW.
// - One sub-module: md_timer (load/decrement counter, done flag, width from MD_LAT).
// - Top: forwarding comparators, load-use detect, FSM + priority resolver.
// TESTING
// - Fwd: RegWriteM=1,addrM=5,RsE=5,MemtoRegM=0; RegWriteW=1,addrW=5 -> ForwardAE=10.
// - Fwd: addrM=0,RegWriteM=1,RsE=0 -> ForwardAE=00; RtE=7,addrW=7,W only -> ForwardBE=01.
// - Load-use: lw $8 in EX, add rs=$8 in ID -> one cycle StallF/StallD/FlushE, then fwd 11.
// - Branch: BranchE=1,ZeroE=1 with concurrent load-use -> FlushD=FlushE=1, StallF=0.
// - MUL/DIV MD_LAT=4: MulDivE pulse -> StallE high 4 cycles, MulDivBusy 3, then IDLE.
// - rst=1 on 2nd MD_BUSY cycle -> next cycle all outputs 0, state IDLE, md_cnt=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline control.
// - REG_AW     : default register address width
// - FWD_*      : EX-stage operand forwarding select codes
// - hz_state_t : hazard controller FSM states
package mips_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_RF   = 2'b00;  // register file read data
  localparam logic [1:0] FWD_WB   = 2'b01;  // WB-stage result
  localparam logic [1:0] FWD_ALUM = 2'b10;  // ALU result held in MEM
  localparam logic [1:0] FWD_MEMD = 2'b11;  // load data read in MEM

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/md_timer.sv
// MUL/DIV occupancy timer.
// - clk_i  : clock
// - rst_i  : synchronous active-high reset, clears the count
// - load_i : start a sequence; count loads MD_LAT-1
// - done_o : high while the count is 1, i.e. the last held cycle before EX is released
// The count decrements every cycle while non-zero and idles at zero.
module md_timer #(
  parameter int unsigned MD_LAT = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(MD_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(MD_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Inputs : clk, rst (sync, active-high), ID/EX source regs, EX/MEM/WB destination regs
//          with write enables, load flags (E/M), BranchE/ZeroE, MulDivE.
// Outputs: ForwardAE/ForwardBE operand selects, StallF/StallD/StallE,
//          FlushD/FlushE/FlushM, MulDivBusy.
// Event priority: rst > taken branch > MUL/DIV hold > load-use stall.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned AW     = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] RsD,
  input  logic [AW-1:0] RtD,
  input  logic [AW-1:0] RsE,
  input  logic [AW-1:0] RtE,
  input  logic [AW-1:0] RegWriteAddrE,
  input  logic [AW-1:0] RegWriteAddrM,
  input  logic [AW-1:0] RegWriteAddrW,
  input  logic          RegWriteE,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          MemtoRegE,
  input  logic          MemtoRegM,
  input  logic          BranchE,
  input  logic          ZeroE,
  input  logic          MulDivE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushM,
  output logic          MulDivBusy
);

  hz_state_t state_q, state_d;

  logic       br_taken, lu_hazard, md_start, md_hold, md_done;
  logic       m_hit_a, m_hit_b, w_hit_a, w_hit_b;
  logic [1:0] fwd_a, fwd_b;

  // Forwarding: the MEM-stage producer is younger than WB, so it wins. Reg 0 never forwards.
  assign m_hit_a = RegWriteM && (RegWriteAddrM != '0) && (RegWriteAddrM == RsE);
  assign m_hit_b = RegWriteM && (RegWriteAddrM != '0) && (RegWriteAddrM == RtE);
  assign w_hit_a = RegWriteW && (RegWriteAddrW != '0) && (RegWriteAddrW == RsE);
  assign w_hit_b = RegWriteW && (RegWriteAddrW != '0) && (RegWriteAddrW == RtE);

  always_comb begin
    fwd_a = FWD_RF;
    if (m_hit_a)      fwd_a = MemtoRegM ? FWD_MEMD : FWD_ALUM;
    else if (w_hit_a) fwd_a = FWD_WB;
    fwd_b = FWD_RF;
    if (m_hit_b)      fwd_b = MemtoRegM ? FWD_MEMD : FWD_ALUM;
    else if (w_hit_b) fwd_b = FWD_WB;
  end

  assign br_taken  = BranchE && ZeroE;
  assign lu_hazard = MemtoRegE && RegWriteE && (RegWriteAddrE != '0) &&
                     ((RegWriteAddrE == RsD) || (RegWriteAddrE == RtD));
  // A MUL/DIV sharing EX with a taken branch is on the squashed path and never starts.
  assign md_start  = (state_q == IDLE) && MulDivE && !br_taken;
  assign md_hold   = (state_q == MD_BUSY) || md_start;

  md_timer #(
    .MD_LAT (MD_LAT)
  ) u_md_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (md_start),
    .done_o (md_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (md_start) state_d = MD_BUSY;
      MD_BUSY: if (md_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ForwardAE  = FWD_RF;
    ForwardBE  = FWD_RF;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    MulDivBusy = 1'b0;
    if (!rst) begin
      ForwardAE  = fwd_a;
      ForwardBE  = fwd_b;
      MulDivBusy = (state_q == MD_BUSY);
      if (br_taken) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (md_hold) begin
        // Load-use is ignored here; it is seen again once EX is released.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (lu_hazard) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

endmodule
